// File: rtl/imm_gen_pkg.sv
// imm_gen_pkg: RV32I opcodes and immediate format tags shared by the immediate generator.
package imm_gen_pkg;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_OPIMM  = 7'b0010011;
   localparam logic [6:0] OP_OP     = 7'b0110011;
   localparam logic [6:0] OP_FENCE  = 7'b0001111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;
   localparam logic [2:0] IMM_NONE  = 3'd0;
   localparam logic [2:0] IMM_I     = 3'd1;
   localparam logic [2:0] IMM_S     = 3'd2;
   localparam logic [2:0] IMM_B     = 3'd3;
   localparam logic [2:0] IMM_U     = 3'd4;
   localparam logic [2:0] IMM_J     = 3'd5;
   localparam logic [2:0] IMM_Z     = 3'd6;
endpackage

// File: rtl/imm_decode_comb.sv
// imm_decode_comb: combinational RV32I opcode -> immediate/format decoder.
// Define CSR_ZIMM_EN to decode the 5-bit zimm of csrrwi/csrrsi/csrrci as IMM_Z.
module imm_decode_comb
   import imm_gen_pkg::*;
(
   input  logic [31:0] instruction,
   output logic [31:0] immediate,
   output logic [2:0]  imm_type,
   output logic        illegal
);
   logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
   assign imm_i = {{20{instruction[31]}}, instruction[31:20]};
   assign imm_s = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
   assign imm_b = {{19{instruction[31]}}, instruction[31], instruction[7], instruction[30:25], instruction[11:8], 1'b0};
   assign imm_u = {instruction[31:12], 12'b0};
   assign imm_j = {{11{instruction[31]}}, instruction[31], instruction[19:12], instruction[20], instruction[30:21], 1'b0};
   always_comb begin
      immediate = '0;
      imm_type  = IMM_NONE;
      illegal   = 1'b0;
      case (instruction[6:0])
         OP_OPIMM, OP_LOAD, OP_JALR, OP_FENCE: begin
            immediate = imm_i;
            imm_type  = IMM_I;
         end
         OP_SYSTEM: begin
`ifdef CSR_ZIMM_EN
            immediate = instruction[14] ? {27'b0, instruction[19:15]} : imm_i;
            imm_type  = instruction[14] ? IMM_Z : IMM_I;
`else
            immediate = imm_i;
            imm_type  = IMM_I;
`endif
         end
         OP_STORE: begin
            immediate = imm_s;
            imm_type  = IMM_S;
         end
         OP_BRANCH: begin
            immediate = imm_b;
            imm_type  = IMM_B;
         end
         OP_LUI, OP_AUIPC: begin
            immediate = imm_u;
            imm_type  = IMM_U;
         end
         OP_JAL: begin
            immediate = imm_j;
            imm_type  = IMM_J;
         end
         OP_OP: ;
         default: illegal = 1'b1;
      endcase
   end
endmodule

// File: rtl/imm_gen_32bit.sv
// imm_gen_32bit: registered RV32I immediate generator; outputs hold while in_valid is low.
// Optional CSR_ZIMM_EN enables the IMM_Z format for CSR immediate instructions.
module imm_gen_32bit
   import imm_gen_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   input  logic [31:0]     instruction,
   output logic            out_valid,
   output logic [XLEN-1:0] immediate,
   output logic [2:0]      imm_type,
   output logic            illegal
);
   logic [31:0] dec_imm;
   logic [2:0]  dec_type;
   logic        dec_ill;
   logic            valid_d, valid_q, ill_d, ill_q;
   logic [XLEN-1:0] imm_d, imm_q;
   logic [2:0]      type_d, type_q;
   imm_decode_comb u_dec (
      .instruction (instruction),
      .immediate   (dec_imm),
      .imm_type    (dec_type),
      .illegal     (dec_ill)
   );
   always_comb begin
      valid_d = in_valid;
      imm_d   = in_valid ? dec_imm  : imm_q;
      type_d  = in_valid ? dec_type : type_q;
      ill_d   = in_valid ? dec_ill  : ill_q;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= 1'b0;
         imm_q   <= '0;
         type_q  <= IMM_NONE;
         ill_q   <= 1'b0;
      end else begin
         valid_q <= valid_d;
         imm_q   <= imm_d;
         type_q  <= type_d;
         ill_q   <= ill_d;
      end
   end
   assign out_valid = valid_q;
   assign immediate = imm_q;
   assign imm_type  = type_q;
   assign illegal   = ill_q;
endmodule

// File: tb/tb_imm_gen_32bit.sv
// tb_imm_gen_32bit: directed plus randomized checks of imm_gen_32bit against an arithmetic reference model.
module tb_imm_gen_32bit;
   logic        clk = 1'b0;
   logic        rst, in_valid, out_valid, illegal;
   logic [31:0] instruction, immediate;
   logic [2:0]  imm_type;
   int checks = 0, failures = 0;
   logic [31:0] e_imm;
   logic [2:0]  e_type;
   logic        e_ill, e_valid;
   logic [6:0]  legal_ops [12] = '{7'h13, 7'h03, 7'h67, 7'h0F, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h73};

   always #5 clk = ~clk;

   imm_gen_32bit #(.XLEN(32)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .instruction (instruction),
      .out_valid   (out_valid),
      .immediate   (immediate),
      .imm_type    (imm_type),
      .illegal     (illegal)
   );

   function automatic int sx(input int v, input int bits);
      return (v >= (1 << (bits - 1))) ? v - (1 << bits) : v;
   endfunction

   task automatic model(input logic [31:0] w);
      e_imm = 0; e_type = 0; e_ill = 0;
      case (w[6:0])
         7'h13, 7'h03, 7'h67, 7'h0F: begin e_imm = sx(int'(w[31:20]), 12); e_type = 1; end
         7'h73: begin
            e_imm = sx(int'(w[31:20]), 12); e_type = 1;
`ifdef CSR_ZIMM_EN
            if (w[14]) begin e_imm = int'(w[19:15]); e_type = 6; end
`endif
         end
         7'h23: begin e_imm = sx(int'(w[31:25]) * 32 + int'(w[11:7]), 12); e_type = 2; end
         7'h63: begin e_imm = sx(int'(w[31]) * 4096 + int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2, 13); e_type = 3; end
         7'h37, 7'h17: begin e_imm = w - (w % 4096); e_type = 4; end
         7'h6F: begin e_imm = sx(int'(w[31]) * (1 << 20) + int'(w[19:12]) * 4096 + int'(w[20]) * 2048 + int'(w[30:21]) * 2, 21); e_type = 5; end
         7'h33: ;
         default: e_ill = 1;
      endcase
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s instr=%h got=%h expected=%h", tag, instruction, got, exp);
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, "_valid"}, {31'b0, out_valid}, {31'b0, e_valid});
      chk({tag, "_imm"}, immediate, e_imm);
      chk({tag, "_type"}, {29'b0, imm_type}, {29'b0, e_type});
      chk({tag, "_ill"}, {31'b0, illegal}, {31'b0, e_ill});
   endtask

   task automatic step(input logic v, input logic [31:0] w, input string tag);
      in_valid = v;
      instruction = w;
      @(posedge clk);
      #1;
      if (v) model(w);
      e_valid = v;
      check_all(tag);
   endtask

   task automatic step_k(input logic [31:0] w, input logic [31:0] k_imm, input logic [2:0] k_type, input string tag);
      step(1'b1, w, tag);
      chk({tag, "_const_imm"}, immediate, k_imm);
      chk({tag, "_const_type"}, {29'b0, imm_type}, {29'b0, k_type});
   endtask

   initial begin
      logic [31:0] w;
      rst = 1'b1; in_valid = 1'b0; instruction = '0;
      e_imm = 0; e_type = 0; e_ill = 0; e_valid = 0;
      #12;
      check_all("reset");
      @(negedge clk);
      rst = 1'b0;
      step_k(32'h00C00933, 32'h00000000, 3'd0, "add");
      step_k(32'hFE012A83, 32'hFFFFFFE0, 3'd1, "lw");
      step_k(32'h00112423, 32'h00000008, 3'd2, "sw");
      step_k(32'h00504463, 32'h00000008, 3'd3, "blt");
      step_k(32'h10000537, 32'h10000000, 3'd4, "lui");
      step_k(32'hFF1FF06F, 32'hFFFFFFF0, 3'd5, "jal");
      step_k(32'h4051D093, 32'h00000405, 3'd1, "srai");
      step_k(32'h0000007F, 32'h00000000, 3'd0, "illegal");
      chk("illegal_flag", {31'b0, illegal}, 32'd1);
      step(1'b0, 32'h00112423, "hold");
      chk("hold_const_imm", immediate, 32'h0);
      chk("hold_const_ill", {31'b0, illegal}, 32'd1);
`ifdef CSR_ZIMM_EN
      step_k(32'h3400D073, 32'h00000001, 3'd6, "csrrwi");
`else
      step_k(32'h3400D073, 32'h00000340, 3'd1, "csrrwi");
`endif
      step_k(32'h34001073, 32'h00000340, 3'd1, "csrrw");
      for (int n = 0; n < 400; n++) begin
         w = $urandom;
         if ($urandom_range(0, 3) != 0) w[6:0] = legal_ops[$urandom_range(0, 11)];
         step($urandom_range(0, 4) != 0, w, "rand");
      end
      step(1'b1, 32'hFE012A83, "pre_rst");
      #2;
      rst = 1'b1;
      #1;
      e_imm = 0; e_type = 0; e_ill = 0; e_valid = 0;
      check_all("async_rst");
      in_valid = 1'b1;
      instruction = 32'h10000537;
      @(posedge clk);
      #1;
      check_all("rst_hold");
      @(negedge clk);
      rst = 1'b0;
      step(1'b1, 32'hFF1FF06F, "post_rst");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
